gmii_rx_align: RTL
==================

// Module: gmii_rx_align
// PURPOSE
//  PHY-side receive front end; sits directly upstream of the receive MAC.
//  Registers raw GMII/MII pins, strips preamble/SFD, packs MII nibbles into bytes and delivers a clean byte stream.
//  Output is per-frame framed (sof/eof) with error flag and length, all in rx_clk domain.
// PARAMETERS
//  DELAY    2     simulation-only #delay on all nonblocking assignments
//  MAX_PRE  15    max preamble bytes (0x55) accepted before SFD; exceeded -> frame dropped
//  MAX_LEN  1518  max delivered bytes per frame (DA..FCS); excess bytes suppressed, err set
// PORTS
//  rstn        in   1   asynchronous reset, active-low
//  rx_clk      in   1   PHY receive clock (125/25/2.5 MHz)
//  speed       in   2   00:10M 01:100M 10:1000M; speed[1]=1 -> byte mode, else nibble mode
//  rx_dv       in   1   PHY data valid
//  rx_er       in   1   PHY receive error
//  rxd         in   8   PHY data; nibble mode uses rxd[3:0] only
//  out_dv      out  1   one-cycle strobe: out_d holds a frame byte
//  out_d       out  8   frame byte, first byte = DA[0]
//  out_sof     out  1   high with out_dv on first byte of frame
//  out_eof     out  1   one-cycle pulse after last byte, out_dv=0 in that cycle
//  out_err     out  1   valid with out_eof: frame bad (rx_er/dribble/oversize)
//  out_len     out  13  valid with out_eof: delivered byte count
//  st_ok       out  32  good-frame counter (RX_STATS_EN)
//  st_bad      out  32  out_err frame counter (RX_STATS_EN)
//  st_drop     out  16  dropped-frame counter (RX_STATS_EN)
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, counters 0. Inputs registered once (dv_r, er_r, d_r) before any decode.
//  - speed sampled into spd_l on each IDLE->PRE/DATA transition; held constant for whole frame.
//  - FSM states IDLE, PRE, DATA, DROP. "unit" = byte (byte mode) or nibble (nibble mode).
//  - IDLE: on dv_r rising (dv_r & !dv_r_prev): unit==SFD (0xD5 / 0xD) -> DATA; unit==0x55/0x5 -> PRE; else -> DROP.
//    No rising edge seen -> stay; a frame already active at reset release is ignored until dv low.
//  - PRE: dv_r low -> IDLE (no eof, no stats). SFD -> DATA, nibble phase=0, byte cnt=0.
//    0x55/0x5 -> pre_cnt+1 (counted in bytes; nibble pairs); pre_cnt>MAX_PRE or any other value -> DROP.
//  - DATA, nibble mode: phase0 stores rxd[3:0] as low nibble; phase1 forms {rxd[3:0],low} and emits byte.
//  - DATA, byte mode: every dv_r cycle emits byte.
//  - Emit: out_dv=1, out_d=byte, out_sof=(cnt==0), cnt+1 (13-bit, saturates 8191). cnt>=MAX_LEN -> byte suppressed, err=1.
//  - er_r=1 at any point in DATA sets sticky err.
//  - DATA, dv_r low: dribble (phase1 pending) -> partial nibble discarded, err=1.
//    Next cycle: out_eof=1, out_err=err, out_len=min(cnt,MAX_LEN) -> IDLE.
//  - cnt==0 at dv fall (SFD then dv low): eof still emitted, out_len=0, out_err=1.
//  - DROP: no output; wait dv_r low -> IDLE; st_drop+1 on entry.
//  - Latency: rxd -> out_d = 2 cycles after the completing unit (input reg + output reg). out_eof 2 cycles after rx_dv falls.
//  - out_eof/out_err/out_len registered; out_err/out_len hold until next eof; out_dv/out_sof/out_eof pulse 1 cycle.
//  - dv_r falls and rises in back-to-back cycles: eof for old frame and IDLE edge detect for new frame both honoured (IDLE sees edge next cycle via dv_r_prev).
// CONFIGURATION
//  - RX_STATS_EN defined: st_ok/st_bad incremented on out_eof by out_err; st_drop on DROP entry; all saturate at max.
//  - RX_STATS_EN undefined: counters not built, st_* ports tied 0.
// TESTING
//  - 1000M, 7x0x55+0xD5 + 64-byte frame 00..3F -> 64 out_dv, sof on 0x00, eof 2 clk after dv fall, len=64, err=0.
//  - 100M, same frame as nibbles low-first -> identical byte stream, len=64, err=0; extra nibble before dv fall -> err=1, len=64.
//  - rx_er pulse at byte 20 of 100-byte frame -> all 100 bytes delivered, eof err=1, st_bad=1.
//  - 1600-byte frame -> exactly 1518 out_dv, len=1518, err=1.
//  - 20x0x55 then SFD -> DROP, no out_dv/eof, st_drop=1; preamble byte 0x57 -> DROP likewise.
//  - rstn low mid-frame, released with rx_dv still high -> no output until dv low then next frame received normally.

Source files
------------

// File: rtl/gmii_rx_align_if.sv
// Signal bundle between the GMII/MII receive aligner and its environment.
// master: the aligner (takes PHY pins, drives the byte stream); slave: PHY model / MAC side.
interface gmii_rx_align_if;
  logic [1:0]  speed;
  logic        rx_dv;
  logic        rx_er;
  logic [7:0]  rxd;
  logic        out_dv;
  logic [7:0]  out_d;
  logic        out_sof;
  logic        out_eof;
  logic        out_err;
  logic [12:0] out_len;
  logic [31:0] st_ok;
  logic [31:0] st_bad;
  logic [15:0] st_drop;

  modport master (
    input  speed, rx_dv, rx_er, rxd,
    output out_dv, out_d, out_sof, out_eof, out_err, out_len, st_ok, st_bad, st_drop
  );

  modport slave (
    output speed, rx_dv, rx_er, rxd,
    input  out_dv, out_d, out_sof, out_eof, out_err, out_len, st_ok, st_bad, st_drop
  );
endinterface

// File: rtl/gmii_rx_align.sv
// GMII/MII receive front end: registers PHY pins, strips preamble/SFD, packs nibbles, frames bytes.
// Define RX_STATS_EN to build the st_ok/st_bad/st_drop counters; otherwise they read 0.
module gmii_rx_align #(
  parameter int unsigned MAX_PRE = 15,
  parameter int unsigned MAX_LEN = 1518
) (
  input logic             rstn,
  input logic             rx_clk,
  gmii_rx_align_if.master bus
);
  typedef enum logic [1:0] {StIdle, StPre, StData, StDrop} state_e;

  localparam logic [12:0] MaxLenW = 13'(MAX_LEN);
  localparam logic [15:0] MaxPreW = 16'(MAX_PRE);

  state_e      state_q, state_d;
  logic        dv_r_q, dv_p_q, er_r_q;
  logic [7:0]  d_r_q;
  logic        spd_byte_q, spd_byte_d;
  logic [15:0] pre_q, pre_d;
  logic [12:0] cnt_q, cnt_d;
  logic        phase_q, phase_d;
  logic [3:0]  low_q, low_d;
  logic        err_q, err_d;
  logic        out_dv_q, out_dv_d;
  logic [7:0]  out_d_q, out_d_d;
  logic        out_sof_q, out_sof_d;
  logic        out_eof_q, out_eof_d;
  logic        out_err_q, out_err_d;
  logic [12:0] out_len_q, out_len_d;

  logic        byte_mode, unit_sfd, unit_pre, emit;
  logic [7:0]  emit_byte;
  logic [15:0] pre_nxt, pre_bytes;
  logic        unused_speed0;

  assign unused_speed0 = bus.speed[0];

  // Mode comes live from speed only while idle; the latched copy governs the rest of the frame.
  assign byte_mode = (state_q == StIdle) ? bus.speed[1] : spd_byte_q;
  assign unit_sfd  = byte_mode ? (d_r_q == 8'hD5) : (d_r_q[3:0] == 4'hD);
  assign unit_pre  = byte_mode ? (d_r_q == 8'h55) : (d_r_q[3:0] == 4'h5);
  assign pre_nxt   = pre_q + 16'd1;
  assign pre_bytes = byte_mode ? pre_nxt : {1'b0, pre_nxt[15:1]};

  // dv history resets high so a frame already in flight at reset release is not an edge.
  always_ff @(posedge rx_clk or negedge rstn) begin
    if (!rstn) begin
      dv_r_q <= 1'b1;
      dv_p_q <= 1'b1;
      er_r_q <= 1'b0;
      d_r_q  <= '0;
    end else begin
      dv_r_q <= bus.rx_dv;
      dv_p_q <= dv_r_q;
      er_r_q <= bus.rx_er;
      d_r_q  <= bus.rxd;
    end
  end

  always_ff @(posedge rx_clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      spd_byte_q <= 1'b0;
      pre_q      <= '0;
      cnt_q      <= '0;
      phase_q    <= 1'b0;
      low_q      <= '0;
      err_q      <= 1'b0;
      out_dv_q   <= 1'b0;
      out_d_q    <= '0;
      out_sof_q  <= 1'b0;
      out_eof_q  <= 1'b0;
      out_err_q  <= 1'b0;
      out_len_q  <= '0;
    end else begin
      state_q    <= state_d;
      spd_byte_q <= spd_byte_d;
      pre_q      <= pre_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      low_q      <= low_d;
      err_q      <= err_d;
      out_dv_q   <= out_dv_d;
      out_d_q    <= out_d_d;
      out_sof_q  <= out_sof_d;
      out_eof_q  <= out_eof_d;
      out_err_q  <= out_err_d;
      out_len_q  <= out_len_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    spd_byte_d = spd_byte_q;
    pre_d      = pre_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    low_d      = low_q;
    err_d      = err_q;
    out_dv_d   = 1'b0;
    out_d_d    = out_d_q;
    out_sof_d  = 1'b0;
    out_eof_d  = 1'b0;
    out_err_d  = out_err_q;
    out_len_d  = out_len_q;
    emit       = 1'b0;
    emit_byte  = '0;

    unique case (state_q)
      StIdle: begin
        if (dv_r_q && !dv_p_q) begin
          spd_byte_d = bus.speed[1];
          pre_d      = 16'd1;
          cnt_d      = '0;
          phase_d    = 1'b0;
          err_d      = 1'b0;
          if (unit_sfd) begin
            state_d = StData;
          end else if (unit_pre) begin
            state_d = StPre;
          end else begin
            state_d = StDrop;
          end
        end
      end
      StPre: begin
        if (!dv_r_q) begin
          state_d = StIdle;
        end else if (unit_sfd) begin
          state_d = StData;
          phase_d = 1'b0;
          cnt_d   = '0;
          err_d   = 1'b0;
        end else if (unit_pre && (pre_bytes <= MaxPreW)) begin
          pre_d = pre_nxt;
        end else begin
          state_d = StDrop;
        end
      end
      StData: begin
        if (!dv_r_q) begin
          // A pending low nibble at dv fall is dribble; an empty frame is also bad.
          out_eof_d = 1'b1;
          out_err_d = err_q | phase_q | (cnt_q == 13'd0);
          out_len_d = (cnt_q > MaxLenW) ? MaxLenW : cnt_q;
          state_d   = StIdle;
        end else begin
          if (er_r_q) begin
            err_d = 1'b1;
          end
          if (byte_mode) begin
            emit      = 1'b1;
            emit_byte = d_r_q;
          end else if (!phase_q) begin
            low_d   = d_r_q[3:0];
            phase_d = 1'b1;
          end else begin
            emit      = 1'b1;
            emit_byte = {d_r_q[3:0], low_q};
            phase_d   = 1'b0;
          end
          if (emit) begin
            if (cnt_q >= MaxLenW) begin
              err_d = 1'b1;
            end else begin
              out_dv_d  = 1'b1;
              out_d_d   = emit_byte;
              out_sof_d = (cnt_q == 13'd0);
            end
            if (cnt_q != '1) begin
              cnt_d = cnt_q + 13'd1;
            end
          end
        end
      end
      StDrop: begin
        if (!dv_r_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.out_dv  = out_dv_q;
  assign bus.out_d   = out_d_q;
  assign bus.out_sof = out_sof_q;
  assign bus.out_eof = out_eof_q;
  assign bus.out_err = out_err_q;
  assign bus.out_len = out_len_q;

`ifdef RX_STATS_EN
  logic [31:0] st_ok_q, st_bad_q;
  logic [15:0] st_drop_q;
  logic        drop_entry;

  assign drop_entry = (state_d == StDrop) && (state_q != StDrop);

  always_ff @(posedge rx_clk or negedge rstn) begin
    if (!rstn) begin
      st_ok_q   <= '0;
      st_bad_q  <= '0;
      st_drop_q <= '0;
    end else begin
      if (out_eof_d) begin
        if (out_err_d) begin
          if (st_bad_q != '1) st_bad_q <= st_bad_q + 32'd1;
        end else begin
          if (st_ok_q != '1) st_ok_q <= st_ok_q + 32'd1;
        end
      end
      if (drop_entry && (st_drop_q != '1)) begin
        st_drop_q <= st_drop_q + 16'd1;
      end
    end
  end

  assign bus.st_ok   = st_ok_q;
  assign bus.st_bad  = st_bad_q;
  assign bus.st_drop = st_drop_q;
`else
  assign bus.st_ok   = '0;
  assign bus.st_bad  = '0;
  assign bus.st_drop = '0;
`endif
endmodule
